// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (sync, length, big-endian words, XOR checksum)
// into instruction memory writes and holds the core until a frame checks out.
module imem_loader #(
   parameter logic [7:0] SYNC = 8'hA5,
   parameter int         AW   = 9,
   parameter int         DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [DW-1:0] imem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_t;
   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d, idx_q, idx_d, addr_q, addr_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [DW-9:0]   word_q, word_d;
   logic [7:0]      acc_q, acc_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            ready_q, we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
   logic            xfer;
   assign xfer       = in_valid & ready_q;
   assign in_ready   = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign err        = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      err_d   = err_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      if (xfer) begin
         case (state_q)
            IDLE: if (in_data == SYNC) begin
               state_d = LEN0;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               acc_d   = '0;
               idx_d   = '0;
               bcnt_d  = '0;
            end
            LEN0: begin
               cnt_d[7:0] = in_data;
               state_d    = LEN1;
            end
            LEN1: begin
               cnt_d[8] = in_data[0];
               state_d  = DATA;
            end
            DATA: begin
               acc_d  = acc_q ^ in_data;
               bcnt_d = bcnt_q + 2'd1;
               word_d = {word_q[DW-17:0], in_data};
               if (bcnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = idx_q;
                  wdata_d = {word_q, in_data};
                  idx_d   = idx_q + 1'b1;
                  state_d = (idx_q == cnt_q) ? CSUM : DATA;
               end
            end
            CSUM: begin
               done_d  = (in_data == acc_q);
               err_d   = (in_data != acc_q);
               hold_d  = (in_data != acc_q);
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= 1'b1;
         we_q    <= we_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
endmodule
